// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Radix-2 shift-add multiply, restoring divide, then one sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state;
  logic [2:0]       opr;
  logic             sa;
  logic             sb;
  logic             spc;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;

  logic             a_sgn;
  logic             b_sgn;
  logic             sa_in;
  logic             sb_in;
  logic             dz;
  logic             ovf;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] spc_res;

  always_comb begin
    a_sgn = (op == 3'b001) || (op == 3'b010) ||
            (op == 3'b100) || (op == 3'b110);
    b_sgn = (op == 3'b001) || (op == 3'b100) ||
            (op == 3'b110);
    sa_in = a_sgn & a[WIDTH-1];
    sb_in = b_sgn & b[WIDTH-1];
    ma    = sa_in ? -a : a;
    mb    = sb_in ? -b : b;
    dz    = op[2] && (b == '0);
    ovf   = op[2] && !op[0] && (a == MINV) && (b == '1);
    spc_res = '0;
    if (dz)
      spc_res = op[1] ? a : '1;
    else if (ovf)
      spc_res = op[1] ? '0 : a;
  end

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   diff;

  always_comb begin
    addend = lo[0] ? dvs : '0;
    sum    = {1'b0, acc} + {1'b0, addend};
    rs     = {acc, lo[WIDTH-1]};
    diff   = rs - {1'b0, dvs};
  end

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prodf;
  logic [WIDTH-1:0]   quotf;
  logic [WIDTH-1:0]   remf;
  logic [WIDTH-1:0]   fix_res;

  always_comb begin
    prod  = {acc, lo};
    prodf = (sa ^ sb) ? -prod : prod;
    quotf = (sa ^ sb) ? -lo : lo;
    remf  = sa ? -acc : acc;
    if (spc)
      fix_res = lo;
    else if (opr[2])
      fix_res = opr[1] ? remf : quotf;
    else if (opr[1:0] == 2'b00)
      fix_res = prodf[WIDTH-1:0];
    else
      fix_res = prodf[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      opr    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      spc    <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      dvs    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              opr  <= op;
              sa   <= sa_in;
              sb   <= sb_in;
              spc  <= dz | ovf;
              acc  <= '0;
              cnt  <= '0;
              busy <= 1'b1;
              // special cases park their answer in lo
              if (dz | ovf) begin
                lo    <= spc_res;
                state <= FIX;
              end else begin
                lo    <= op[2] ? ma : mb;
                dvs   <= op[2] ? mb : ma;
                state <= CALC;
              end
            end
          end
          CALC: begin
            cnt <= cnt + 1'b1;
            if (opr[2]) begin
              if (!diff[WIDTH]) begin
                acc <= diff[WIDTH-1:0];
                lo  <= {lo[WIDTH-2:0], 1'b1};
              end else begin
                acc <= rs[WIDTH-1:0];
                lo  <= {lo[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc <= sum[WIDTH:1];
              lo  <= {sum[0], lo[WIDTH-1:1]};
            end
            if (cnt == LAST)
              state <= FIX;
          end
          FIX: begin
            result <= fix_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
